// File: rtl/bullet_pool_if.sv
// Bus between the game top level and bullet_pool: fire control, per-slot
// state readback and VGA beam hit flags. NB must match the pool's NB.
interface bullet_pool_if #(
    parameter int NB = 4
);
    logic              clk_en;
    logic              fire_re;
    logic              fire_lvl;
    logic [1:0]        scene;
    logic [8:0]        player_X;
    logic [NB-1:0]     hit;
    logic [8:0]        H_pos;
    logic [8:0]        V_pos;
    logic [9*NB-1:0]   X;
    logic [9*NB-1:0]   Y;
    logic [NB-1:0]     active;
    logic [NB-1:0]     bullet_s;
    logic              any_s;
    logic              fired;
    logic              dropped;

    modport master (
        output clk_en, fire_re, fire_lvl, scene, player_X, hit, H_pos, V_pos,
        input  X, Y, active, bullet_s, any_s, fired, dropped
    );

    modport slave (
        input  clk_en, fire_re, fire_lvl, scene, player_X, hit, H_pos, V_pos,
        output X, Y, active, bullet_s, any_s, fired, dropped
    );
endinterface

// File: rtl/bullet_pool.sv
// Pool of NB player bullets: allocate on fire, move up on game ticks, retire on
// hit or top of screen, beam-hit flags. Optional: BULLET_POOL_AUTOFIRE_EN.
module bullet_pool #(
    parameter int NB       = 4,
    parameter int SPAWN_Y  = 213,
    parameter int X_OFS    = 7,
    parameter int SPEED    = 2,
    parameter int SIZE     = 2,
    parameter int COOLDOWN = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    bullet_pool_if.slave  bus
);
    localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [8:0]    SPAWN_V = 9'(SPAWN_Y);
    localparam logic [8:0]    X_OFS_V = 9'(X_OFS);
    localparam logic [8:0]    SPEED_V = 9'(SPEED);
    localparam logic [9:0]    SIZE_V  = 10'(SIZE);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);

    logic [8:0]    x_q [NB];
    logic [8:0]    y_q [NB];
    logic [NB-1:0] active_q;
    logic [CW-1:0] cd_q;
    logic          fired_q;
    logic          dropped_q;

    logic          live;
    logic          cd_zero;
    logic          fire_req;
    logic          found;
    logic          accept;
    logic          refuse;
    logic [NB-1:0] alloc_oh;
    logic [NB-1:0] hit_v;

    assign live    = (bus.scene == 2'd1);
    assign cd_zero = (cd_q == '0);

`ifdef BULLET_POOL_AUTOFIRE_EN
    // Held button fires on every tick once the cooldown has run out.
    assign fire_req = bus.fire_re | (bus.clk_en & bus.fire_lvl & cd_zero);
`else
    logic unused_fire_lvl;
    assign unused_fire_lvl = bus.fire_lvl;
    assign fire_req        = bus.fire_re;
`endif

    // Lowest-index slot that was free at the start of the cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (!active_q[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign accept = live & fire_req & cd_zero & found;
    assign refuse = live & fire_req & ~accept;
    assign hit_v  = bus.hit & active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the slot array is a handful of registers, not a RAM, so it is reset with everything else.
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            active_q  <= '0;
            cd_q      <= '0;
            fired_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every slot sees pre-edge values.
            for (int i = 0; i < NB; i++) begin
                if (!live || hit_v[i]) begin
                    active_q[i] <= 1'b0;
                    x_q[i]      <= '0;
                    y_q[i]      <= '0;
                end else if (accept && alloc_oh[i]) begin
                    active_q[i] <= 1'b1;
                    x_q[i]      <= bus.player_X + X_OFS_V;
                    y_q[i]      <= SPAWN_V;
                end else if (bus.clk_en && active_q[i]) begin
                    // Retire instead of letting Y wrap past the top of the screen.
                    if (y_q[i] < SPEED_V) begin
                        active_q[i] <= 1'b0;
                        x_q[i]      <= '0;
                        y_q[i]      <= '0;
                    end else begin
                        y_q[i] <= y_q[i] - SPEED_V;
                    end
                end
            end

            if (!live)
                cd_q <= '0;
            else if (accept)
                cd_q <= CD_LOAD;
            else if (bus.clk_en && !cd_zero)
                cd_q <= cd_q - CW'(1);

            fired_q   <= accept;
            dropped_q <= refuse;
        end
    end

    logic [9*NB-1:0] x_flat;
    logic [9*NB-1:0] y_flat;
    logic [NB-1:0]   beam_in;

    // Beam compares are widened to 10 bits so X+SIZE cannot wrap.
    always_comb begin
        x_flat  = '0;
        y_flat  = '0;
        beam_in = '0;
        for (int i = 0; i < NB; i++) begin
            x_flat[9*i +: 9] = x_q[i];
            y_flat[9*i +: 9] = y_q[i];
            beam_in[i] = active_q[i]
                && ({1'b0, bus.H_pos} >= {1'b0, x_q[i]})
                && ({1'b0, bus.H_pos} <  ({1'b0, x_q[i]} + SIZE_V))
                && ({1'b0, bus.V_pos} >= {1'b0, y_q[i]})
                && ({1'b0, bus.V_pos} <  ({1'b0, y_q[i]} + SIZE_V));
        end
    end

    assign bus.X        = x_flat;
    assign bus.Y        = y_flat;
    assign bus.active   = active_q;
    assign bus.bullet_s = beam_in;
    assign bus.any_s    = |beam_in;
    assign bus.fired    = fired_q;
    assign bus.dropped  = dropped_q;
endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool (default parameters): fire outcomes go
// through a scoreboard queue, slot state and beam flags are checked directly.
module tb_bullet_pool;
    localparam int NB      = 4;
    localparam int SPAWN_Y = 213;
    localparam int X_OFS   = 7;

    typedef struct {
        logic       fired;
        int         slot;
        logic [8:0] x;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t mon_e;

    bullet_pool_if #(.NB(NB)) bif ();

    bullet_pool #(.NB(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] x_of(input int s);
        return bif.X[9*s +: 9];
    endfunction

    function automatic logic [8:0] y_of(input int s);
        return bif.Y[9*s +: 9];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            bif.clk_en = 1'b1;
            step();
            bif.clk_en = 1'b0;
            step();
        end
    endtask

    task automatic push_exp(input logic [8:0] px, input logic ef, input int es);
        exp_t t;
        t.fired = ef;
        t.slot  = es;
        t.x     = px + 9'(X_OFS);
        sb.push_back(t);
    endtask

    // One fire_re pulse (optionally with a hit in the same clk); the monitor
    // consumes the expected outcome on the following negedge.
    task automatic fire(input logic [8:0] px, input logic [NB-1:0] hv,
                        input logic ef, input int es);
        push_exp(px, ef, es);
        bif.player_X = px;
        bif.hit      = hv;
        bif.fire_re  = 1'b1;
        step();
        bif.fire_re  = 1'b0;
        bif.hit      = '0;
        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bif.fired || bif.dropped)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {bif.fired, bif.dropped}, 0);
            end else begin
                mon_e = sb.pop_front();
                check("fired", bif.fired, mon_e.fired);
                check("dropped", bif.dropped, !mon_e.fired);
                if (mon_e.fired) begin
                    check("spawn_x", x_of(mon_e.slot), mon_e.x);
                    check("spawn_y", y_of(mon_e.slot), SPAWN_Y);
                    check("spawn_active", bif.active[mon_e.slot], 1);
                end
            end
        end
    end

    initial begin
        logic expb;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bif.clk_en   = 1'b0;
        bif.fire_re  = 1'b0;
        bif.fire_lvl = 1'b0;
        bif.scene    = 2'd0;
        bif.player_X = '0;
        bif.hit      = '0;
        bif.H_pos    = '0;
        bif.V_pos    = '0;
        repeat (3) step();

        check("rst_active", bif.active, 0);
        check("rst_fired", bif.fired, 0);
        check("rst_dropped", bif.dropped, 0);
        for (int s = 0; s < NB; s++) begin
            check("rst_x", x_of(s), 0);
            check("rst_y", y_of(s), 0);
        end
        rst_n     = 1'b1;
        bif.scene = 2'd1;
        step();

        // Basic fire and flight.
        fire(9'd100, '0, 1'b1, 0);
        check("x_107", x_of(0), 107);
        tick(10);
        check("y_after_10", y_of(0), 193);

        // Cooldown: refused 3 ticks in, accepted after the 8th tick.
        fire(9'd20, '0, 1'b1, 1);
        tick(3);
        fire(9'd30, '0, 1'b0, 0);
        tick(5);
        fire(9'd40, '0, 1'b1, 2);

        // Fill the pool, overflow, then free slot 2 with a hit and refill it.
        tick(8);
        fire(9'd510, '0, 1'b1, 3);
        check("x_wrap", x_of(3), 5);
        tick(8);
        fire(9'd70, '0, 1'b0, 0);
        check("pool_full", bif.active, 4'hf);
        bif.hit = 4'b0100;
        step();
        bif.hit = '0;
        check("hit_clears", bif.active, 4'b1011);
        fire(9'd80, '0, 1'b1, 2);
        bif.hit = 4'b0000;

        // Top-of-screen retirement without underflow.
        bif.scene = 2'd0;
        step();
        check("scene_clear", bif.active, 0);
        bif.scene = 2'd1;
        step();
        fire(9'd0, '0, 1'b1, 0);
        tick(105);
        check("y_3", y_of(0), 3);
        tick(1);
        check("y_1", y_of(0), 1);
        tick(1);
        check("top_retire", bif.active[0], 0);
        check("top_no_wrap", y_of(0), 0);

        // Hit on slot 0 together with a fire while 1..3 are full: refused.
        fire(9'd10, '0, 1'b1, 0);
        tick(8);
        fire(9'd11, '0, 1'b1, 1);
        tick(8);
        fire(9'd12, '0, 1'b1, 2);
        tick(8);
        fire(9'd13, '0, 1'b1, 3);
        tick(8);
        fire(9'd14, 4'b0001, 1'b0, 0);
        check("hit_and_fire", bif.active, 4'b1110);

        // Asynchronous reset with three bullets in flight.
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_active", bif.active, 0);
        check("mid_rst_fired", bif.fired, 0);
        check("mid_rst_dropped", bif.dropped, 0);
        for (int s = 0; s < NB; s++) begin
            check("mid_rst_x", x_of(s), 0);
            check("mid_rst_y", y_of(s), 0);
        end
        step();
        rst_n = 1'b1;
        step();

        // Beam window around a bullet at X=50, Y=61 (Y stays odd at SPEED 2).
        fire(9'd43, '0, 1'b1, 0);
        tick(76);
        check("beam_y", y_of(0), 61);
        for (int v = 59; v <= 64; v++) begin
            for (int h = 48; h <= 53; h++) begin
                bif.H_pos = 9'(h);
                bif.V_pos = 9'(v);
                #1;
                expb = (h >= 50 && h <= 51 && v >= 61 && v <= 62);
                check("bullet_s0", bif.bullet_s[0], expb);
                check("any_s", bif.any_s, expb);
            end
        end
        bif.H_pos = 9'd50;
        bif.V_pos = 9'd61;
        bif.scene = 2'd2;
        step();
        check("scene2_clear", bif.active, 0);
        check("scene2_any_s", bif.any_s, 0);
        bif.scene = 2'd1;
        step();

        // Held fire button for 20 ticks.
        bif.player_X = 9'd100;
`ifdef BULLET_POOL_AUTOFIRE_EN
        push_exp(9'd100, 1'b1, 0);
        push_exp(9'd100, 1'b1, 1);
        push_exp(9'd100, 1'b1, 2);
`endif
        bif.fire_lvl = 1'b1;
        tick(20);
        bif.fire_lvl = 1'b0;
        check("autofire_drain", sb.size(), 0);
`ifdef BULLET_POOL_AUTOFIRE_EN
        check("autofire_slots", bif.active, 4'b0111);
`else
        check("no_autofire", bif.active, 0);
`endif

        repeat (2) step();
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
